uart_tx_frame: RTL and testbench

//  Parametrised successor TX serialiser: runtime-selectable 5..p_max_data_bits data bits, optional parity, 1/2 stop bits.

---
 rtl/uart_tx_frame.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit serialiser: runtime 5..p_max_data_bits data bits, optional parity, 1/2 stop bits, one-word hold.
// Optional line-break generation (break_i port, BREAK state) is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame #(
  parameter int p_clk_speed_hz  = 50_000_000,
  parameter int p_baud_rate     = 9_600,
  parameter int p_max_data_bits = 9
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [p_max_data_bits-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [3:0]                 data_bits_i,
  input  logic                       parity_en_i,
  input  logic                       parity_sel_i,
  input  logic                       stop_sel_i,
  output logic                       data_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                       break_i
`endif
);

  localparam int            CPB        = p_clk_speed_hz / p_baud_rate;
  localparam int            CW         = $clog2(CPB) + 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP2_LAST = CW'(2 * CPB - 1);
  localparam logic [3:0]    LEN_MAX    = 4'(p_max_data_bits);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK
`endif
  } state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] bits);
    if (bits < 4'd5) return 4'd5;
    if (bits > LEN_MAX) return LEN_MAX;
    return bits;
  endfunction

  // Odd parity seeds the accumulator with 1 so the frame's total count of ones comes out odd.
  function automatic logic parity_bit(input logic [p_max_data_bits-1:0] d,
                                      input logic [3:0] len, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < p_max_data_bits; i++)
      if (4'(i) < len) p = p ^ d[i];
    return p;
  endfunction

  logic                       hold_full_q;
  logic [p_max_data_bits-1:0] hold_data_q;
  logic [3:0]                 hold_len_q;
  logic                       hold_par_en_q;
  logic                       hold_par_odd_q;
  logic                       hold_stop2_q;

  logic [p_max_data_bits-1:0] sh_data_q;
  logic [3:0]                 len_q;
  logic                       par_en_q;
  logic                       par_q;
  logic                       stop2_q;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [3:0]                 bit_idx_q;
  logic                       data_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       brk_stop_q;

  logic                       accept_w;
  logic                       load_w;
  logic                       shift_w;
  logic                       bit_end_w;
  logic [CW-1:0]              stop_last_w;

  assign ready_o     = ~hold_full_q & ~rst_i;
  assign accept_w    = valid_i & ready_o;
  assign bit_end_w   = (cnt_q == BIT_LAST);
  assign stop_last_w = (stop2_q & ~brk_stop_q) ? STOP2_LAST : BIT_LAST;
  assign shift_w     = bit_end_w & ((state_q == S_START) | (state_q == S_DATA));

  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

  // The held word moves to the shifter when the line is free: from IDLE, or at the last clock of STOP.
  always_comb begin
    load_w = 1'b0;
    if (hold_full_q) begin
      case (state_q)
`ifdef UART_TX_BREAK_EN
        S_IDLE:  load_w = ~break_i;
`else
        S_IDLE:  load_w = 1'b1;
`endif
        S_STOP:  load_w = (cnt_q == stop_last_w);
        default: load_w = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         hold_full_q <= 1'b0;
    else if (accept_w) hold_full_q <= 1'b1;
    else if (load_w)   hold_full_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (accept_w) begin
      hold_data_q    <= data_i;
      hold_len_q     <= clamp_len(data_bits_i);
      hold_par_en_q  <= parity_en_i;
      hold_par_odd_q <= parity_sel_i;
      hold_stop2_q   <= stop_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_w) begin
      sh_data_q <= hold_data_q;
      len_q     <= hold_len_q;
      par_en_q  <= hold_par_en_q;
      par_q     <= parity_bit(hold_data_q, hold_len_q, hold_par_odd_q);
      stop2_q   <= hold_stop2_q;
    end else if (shift_w) begin
      sh_data_q <= sh_data_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      brk_stop_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_i) begin
            state_q <= S_BREAK;
            data_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else
`endif
          if (load_w) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            data_q     <= 1'b0;
            busy_q     <= 1'b1;
            brk_stop_q <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end_w) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= sh_data_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end_w) begin
            cnt_q <= '0;
            if (bit_idx_q == len_q - 4'd1) begin
              state_q <= par_en_q ? S_PARITY : S_STOP;
              data_q  <= par_en_q ? par_q : 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              data_q    <= sh_data_q[0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_end_w) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
            data_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == stop_last_w) begin
            cnt_q      <= '0;
            brk_stop_q <= 1'b0;
            if (load_w) begin
              state_q <= S_START;
              data_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // done_q is registered, so raise it one clock ahead to land on the final stop clock.
            if ((cnt_q + CW'(1) == stop_last_w) && !brk_stop_q) done_q <= 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (!break_i) begin
            state_q    <= S_STOP;
            cnt_q      <= '0;
            data_q     <= 1'b1;
            brk_stop_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          data_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame (CPB=10); expected line bits are queued at stimulus time and checked per clock.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int CPB = 10;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [8:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] data_bits_i;
  logic       parity_en_i;
  logic       parity_sel_i;
  logic       stop_sel_i;
  logic       data_o;
  logic       busy_o;
  logic       done_o;
`ifdef UART_TX_BREAK_EN
  logic       break_i;
`endif

  always #5 clk_i = ~clk_i;

  uart_tx_frame #(
    .p_clk_speed_hz (1_000_000),
    .p_baud_rate    (100_000),
    .p_max_data_bits(9)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_bits_i (data_bits_i),
    .parity_en_i (parity_en_i),
    .parity_sel_i(parity_sel_i),
    .stop_sel_i  (stop_sel_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef UART_TX_BREAK_EN
    ,
    .break_i     (break_i)
`endif
  );

  typedef struct {
    logic val;
    logic last;
  } bit_t;

  bit_t exp_q[$];
  bit_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_active = 1'b0;
  int   mon_cnt    = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Scoreboard model of one frame: one entry per bit period.
  task automatic push_frame(input logic [8:0] d, input int bits, input bit pen,
                            input bit podd, input bit stop2);
    int   len;
    logic p;
    bit_t b;
    len = (bits < 5) ? 5 : ((bits > 9) ? 9 : bits);
    b.val = 1'b0; b.last = 1'b0;
    exp_q.push_back(b);
    p = 1'b0;
    for (int i = 0; i < len; i++) begin
      b.val = d[i];
      exp_q.push_back(b);
      p = p ^ d[i];
    end
    if (pen) begin
      b.val = podd ? ~p : p;
      exp_q.push_back(b);
    end
    b.val = 1'b1;
    if (stop2) exp_q.push_back(b);
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic drive(input logic [8:0] d, input int bits, input bit pen,
                       input bit podd, input bit stop2);
    data_i       = d;
    data_bits_i  = 4'(bits);
    parity_en_i  = pen;
    parity_sel_i = podd;
    stop_sel_i   = stop2;
    valid_i      = 1'b1;
  endtask

  task automatic scramble();
    valid_i      = 1'b0;
    data_i       = ~data_i;
    data_bits_i  = 4'd5;
    parity_en_i  = ~parity_en_i;
    parity_sel_i = ~parity_sel_i;
    stop_sel_i   = ~stop_sel_i;
  endtask

  task automatic send_first(input logic [8:0] d, input int bits, input bit pen,
                            input bit podd, input bit stop2);
    @(negedge clk_i);
    chk("ready_idle", ready_o, 1'b1);
    drive(d, bits, pen, podd, stop2);
    push_frame(d, bits, pen, podd, stop2);
    @(posedge clk_i); #1;
    scramble();
    @(negedge clk_i);
    chk("lat_line", data_o, 1'b1);
    chk("lat_ready", ready_o, 1'b0);
    chk("lat_busy", busy_o, 1'b0);
    @(posedge clk_i); #1;
    mon_cnt    = 0;
    mon_active = 1'b1;
  endtask

  task automatic send_queued(input logic [8:0] d, input int bits, input bit pen,
                             input bit podd, input bit stop2);
    int t;
    t = 0;
    @(negedge clk_i);
    while (!ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    chk("q_ready", ready_o, 1'b1);
    drive(d, bits, pen, podd, stop2);
    push_frame(d, bits, pen, podd, stop2);
    @(posedge clk_i); #1;
    scramble();
    chk("q_held", ready_o, 1'b0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (mon_active && t < 3000) begin
      @(posedge clk_i);
      t++;
    end
    chk("mon_timeout", mon_active, 1'b0);
    if (mon_active) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
      exp_q.delete();
    end
    @(negedge clk_i);
    chk("idle_line", data_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_done", done_o, 1'b0);
    chk("idle_ready", ready_o, 1'b1);
  endtask

  always @(negedge clk_i) begin
    if (mon_active) begin
      if (mon_cnt == 0) cur = exp_q.pop_front();
      chk("line", data_o, cur.val);
      chk("done", done_o, cur.last && (mon_cnt == CPB - 1));
      chk("busy", busy_o, 1'b1);
      mon_cnt++;
      if (mon_cnt == CPB) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_low;
    bit saw_done;
    bit saw_busy;
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    data_i       = '0;
    data_bits_i  = 4'd8;
    parity_en_i  = 1'b0;
    parity_sel_i = 1'b0;
    stop_sel_i   = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_i      = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_line", data_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", ready_o, 1'b1);

    // 8N1 0xA5
    send_first(9'h0A5, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // 7E2 0x41
    send_first(9'h041, 7, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // 9O1 0x1FF then 0x000 queued back-to-back
    send_first(9'h1FF, 9, 1'b1, 1'b1, 1'b0);
    send_queued(9'h000, 9, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Length clamping, upper bits ignored for line and parity
    send_first(9'h1A3, 3, 1'b1, 1'b0, 1'b0);
    wait_idle();
    send_first(9'h155, 12, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // 6O1 followed by a queued 5E2
    send_first(9'h12D, 6, 1'b1, 1'b1, 1'b0);
    send_queued(9'h0F6, 5, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Reset at clock 35 of a frame with a word queued
    send_first(9'h0F0, 8, 1'b0, 1'b0, 1'b0);
    send_queued(9'h033, 8, 1'b0, 1'b0, 1'b0);
    repeat (33) @(negedge clk_i);
    mon_active = 1'b0;
    mon_cnt    = 0;
    exp_q.delete();
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", ready_o, 1'b0);
    @(negedge clk_i);
    chk("midrst_line", data_o, 1'b1);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("midrst_rel_ready", ready_o, 1'b1);
    saw_low  = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk_i);
      if (data_o !== 1'b1) saw_low = 1'b1;
      if (done_o !== 1'b0) saw_done = 1'b1;
      if (busy_o !== 1'b0) saw_busy = 1'b1;
    end
    chk("midrst_no_frame", saw_low, 1'b0);
    chk("midrst_no_done", saw_done, 1'b0);
    chk("midrst_no_busy", saw_busy, 1'b0);

    // Normal operation after the aborted frame
    send_first(9'h03C, 8, 1'b1, 1'b0, 1'b0);
    wait_idle();

`ifdef UART_TX_BREAK_EN
    // Break for 50 clocks with a word queued during it, then a 1-CPB mark, then the word
    @(negedge clk_i);
    break_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      chk("brk_line", data_o, 1'b0);
      chk("brk_busy", busy_o, 1'b1);
      chk("brk_done", done_o, 1'b0);
      if (i == 0) begin
        bit_t m;
        drive(9'h0C3, 8, 1'b0, 1'b0, 1'b1);
        m.val = 1'b1; m.last = 1'b0;
        exp_q.push_back(m);
        push_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1);
      end
      if (i == 1) scramble();
      if (i == 49) break_i = 1'b0;
    end
    @(posedge clk_i); #1;
    mon_cnt    = 0;
    mon_active = 1'b1;
    wait_idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
